fp_div_iter: RTL and testbench
==============================

# fp_div_iter

Iterative, parametrised IEEE-754-style floating-point divider computing quotient = dividend / divisor. It is the sequential successor to the team's single-precision combinational divider: exponent and mantissa widths are parameters, and a radix-2 restoring mantissa datapath is reused over many cycles instead of being unrolled. Valid/ready handshakes on both sides let it sit between pipeline stages of the FP unit. It also reports exception flags.

## Interface
- EXP_W, default 8, exponent field width (≥3)
- MAN_W, default 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands; high only in IDLE
- dividend  in  W  numerator {sign, exp, frac}
- divisor  in  W  denominator {sign, exp, frac}
- out_valid  out  1  quotient/flags valid
- out_ready  in  1  consumer takes result
- quotient  out  W  result
- flags  out  4  {invalid, div_by_zero, overflow, underflow}

## Operation
- FSM states: IDLE → UNPACK → ITER → NORM → DONE → IDLE; UNPACK → DONE directly for special operands.
- IDLE: in_ready=1. When in_valid && in_ready, register both operands and go to UNPACK.
- UNPACK: classify operands. Exponent 0 (zero or subnormal) is treated as zero (flush-to-zero). Special results resolve here, in this priority:
  - any NaN → canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0).
  - 0/0 or inf/inf → canonical qNaN, invalid=1.
  - finite/0 → signed inf, div_by_zero=1.
  - inf/finite → signed inf.
  - finite/inf or 0/finite → signed zero.
  - Result sign is XOR of operand signs except for NaN.
  - Otherwise prepend the hidden 1 to both mantissas, set the biased exponent to eA−eB+bias (signed, EXP_W+2 bits), and go to ITER.
- ITER: MAN_W+3 restoring steps, one quotient bit per cycle, MSB first. Each step computes remainder−divisor mantissa; if non-negative, keep the difference and set the bit to 1. Shift the remainder left by 1. The final non-zero remainder forms the sticky bit.
- NORM:
  - If the quotient MSB is 0, shift left by 1 and decrement the exponent.
  - Round (see Configuration).
  - If rounding carries out of the mantissa, renormalise and increment the exponent.
  - Exponent ≥ all-ones → signed inf, overflow=1.
  - Exponent ≤ 0 → signed zero, underflow=1.
- DONE: out_valid=1. quotient and flags stay stable until out_ready=1, then go to IDLE.
- Reset mid-operation aborts the computation; the partial result is discarded and never presented.

## Timing
- Reset values: in_ready=0 while rst_n=0 and 1 after release (state IDLE). out_valid=0, quotient=0, flags=0.
- Normal operands: out_valid rises MAN_W+5 rising edges after the accept edge (28 for default widths).
- Special operands: out_valid rises 2 edges after the accept edge.
- Result handoff occurs on the edge where out_valid && out_ready. in_ready rises on the following cycle, so there is a minimum 1 idle cycle between results.
- With out_ready held high, throughput is one division per MAN_W+6 cycles.
- in_valid asserted outside IDLE is ignored. Operands are sampled only on the accept edge, so later input changes have no effect.
- flags are cleared on accept and are valid only with out_valid.

## Configuration
- FP_DIV_ROUND_EN defined: round-to-nearest-even using guard, round and sticky bits. Increment when guard && (round || sticky || lsb).
- Undefined: truncate (round toward zero). Guard, round and sticky bits are computed but ignored.
- Latency is identical in both builds.

## Test plan
- 32-bit default widths: 0x40C00000 / 0x40000000 (6/2) → quotient 0x40400000, flags 0, out_valid at accept+28.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB with FP_DIV_ROUND_EN, 0x3EAAAAAA without.
- Specials:
  - 0x3F800000/0x00000000 → 0x7F800000, div_by_zero, latency 2.
  - 0x00000000/0x00000000 → 0x7FC00000, invalid.
  - 0xFF800000/0x40000000 → 0xFF800000.
- Range:
  - 0x7F000000/0x3E800000 → 0x7F800000, overflow.
  - 0x00800000/0x4B000000 → 0x00000000, underflow.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid; quotient and flags stay stable and in_ready=0. Pulse in_valid with other operands meanwhile; they are ignored.
- Reset: assert rst_n=0 in ITER cycle 10, then release. out_valid stays 0, in_ready=1. A new 6/2 division completes correctly.

Source files
------------

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754-style divider: quotient = dividend / divisor, radix-2 restoring, flush-to-zero.
// Latency: out_valid seen on the (MAN_W+5)th edge after accept, on the 2nd edge for special operands.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Macro FP_DIV_ROUND_EN selects RNE, else truncate.
module fp_div_iter #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] quotient,
   output logic [3:0]   flags
);

   // M: mantissa with hidden bit, QW: quotient bits produced, EW: signed working exponent
   localparam int M     = MAN_W + 1;
   localparam int QW    = MAN_W + 3;
   localparam int EW    = EXP_W + 2;
   localparam int CNT_W = $clog2(MAN_W + 2);

   localparam logic [EW-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
   localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
   localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FP_DIV_ROUND_EN
   localparam logic RND_EN = 1'b1;
`else
   localparam logic RND_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_ITER,
      S_NORM,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic               sign_q, sign_d;
   logic [EW-1:0]      exp_q, exp_d;
   logic [M-1:0]       div_q, div_d;
   logic [M:0]         rem_q, rem_d;
   logic [QW-1:0]      quo_q, quo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]       quotient_q, quotient_d;
   logic [3:0]         flags_q, flags_d;

   // operand fields of the registered inputs
   logic               a_s, b_s, sign_x;
   logic [EXP_W-1:0]   a_e, b_e;
   logic [MAN_W-1:0]   a_f, b_f;
   logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign a_s    = a_q[W-1];
   assign b_s    = b_q[W-1];
   assign a_e    = a_q[W-2:MAN_W];
   assign b_e    = b_q[W-2:MAN_W];
   assign a_f    = a_q[MAN_W-1:0];
   assign b_f    = b_q[MAN_W-1:0];
   assign sign_x = a_s ^ b_s;

   // exponent zero covers both zero and subnormal (flushed)
   assign a_zero = (a_e == '0);
   assign b_zero = (b_e == '0);
   assign a_inf  = (&a_e) && (a_f == '0);
   assign b_inf  = (&b_e) && (b_f == '0);
   assign a_nan  = (&a_e) && (a_f != '0);
   assign b_nan  = (&b_e) && (b_f != '0);

   // special-operand resolution, highest priority first
   logic               spec_vld;
   logic [W-1:0]       spec_res;
   logic [3:0]         spec_flg;

   // classify operands and pick the special result, if any
   always_comb begin
      spec_vld = 1'b0;
      spec_res = '0;
      spec_flg = 4'b0000;
      if (a_nan || b_nan) begin
         spec_vld = 1'b1;
         spec_res = QNAN;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_vld = 1'b1;
         spec_res = QNAN;
         spec_flg = 4'b1000;
      end else if (a_inf) begin
         spec_vld = 1'b1;
         spec_res = {sign_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_zero) begin
         spec_vld = 1'b1;
         spec_res = {sign_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         spec_flg = 4'b0100;
      end else if (b_inf || a_zero) begin
         spec_vld = 1'b1;
         spec_res = {sign_x, {(W-1){1'b0}}};
      end
   end

   // one restoring step; in UNPACK it runs on the fresh mantissas so the first bit costs no extra cycle
   logic [M:0]         step_rem_in;
   logic [M-1:0]       step_div_in;
   logic [M+1:0]       step_diff;
   logic               step_bit;
   logic [M:0]         step_keep;
   logic [M:0]         step_rem_out;

   // restoring subtract-compare-shift
   always_comb begin
      step_rem_in  = (state_q == S_UNPACK) ? {1'b0, 1'b1, a_f} : rem_q;
      step_div_in  = (state_q == S_UNPACK) ? {1'b1, b_f} : div_q;
      step_diff    = {1'b0, step_rem_in} - {2'b00, step_div_in};
      step_bit     = ~step_diff[M+1];
      step_keep    = step_bit ? step_diff[M:0] : step_rem_in;
      step_rem_out = step_keep << 1;
   end

   // normalisation, rounding and range check of the finished quotient
   logic [M-1:0]       n_mant;
   logic               n_g, n_r, n_s, n_inc;
   logic [EW-1:0]      n_exp, n_exp_r;
   logic [M:0]         n_sum;
   logic [MAN_W-1:0]   n_frac;
   logic [W-1:0]       n_res;
   logic [3:0]         n_flg;

   // normalise, round, then saturate to inf or flush to zero
   always_comb begin
      if (quo_q[QW-1]) begin
         n_mant = quo_q[QW-1:2];
         n_g    = quo_q[1];
         n_r    = quo_q[0];
         n_exp  = exp_q;
      end else begin
         n_mant = quo_q[QW-2:1];
         n_g    = quo_q[0];
         n_r    = 1'b0;
         n_exp  = exp_q - EW'(1);
      end
      n_s     = (rem_q != '0);
      n_inc   = RND_EN & n_g & (n_r | n_s | n_mant[0]);
      n_sum   = {1'b0, n_mant} + {{M{1'b0}}, n_inc};
      n_exp_r = n_sum[M] ? (n_exp + EW'(1)) : n_exp;
      n_frac  = n_sum[M] ? n_sum[MAN_W:1] : n_sum[MAN_W-1:0];
      n_res   = {sign_q, n_exp_r[EXP_W-1:0], n_frac};
      n_flg   = 4'b0000;
      if (!n_exp_r[EW-1] && (n_exp_r >= EXP_MAX)) begin
         n_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         n_flg = 4'b0010;
      end else if (n_exp_r[EW-1] || (n_exp_r == '0)) begin
         n_res = {sign_q, {(W-1){1'b0}}};
         n_flg = 4'b0001;
      end
   end

   assign in_ready  = (state_q == S_IDLE) & rst_n;
   assign out_valid = (state_q == S_DONE);
   assign quotient  = quotient_q;
   assign flags     = flags_q;

   // control FSM: next state and next value of every datapath register
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      div_d      = div_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      quotient_d = quotient_q;
      flags_d    = flags_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               a_d        = dividend;
               b_d        = divisor;
               quotient_d = '0;
               flags_d    = 4'b0000;
               state_d    = S_UNPACK;
            end
         end
         S_UNPACK: begin
            if (spec_vld) begin
               quotient_d = spec_res;
               flags_d    = spec_flg;
               state_d    = S_DONE;
            end else begin
               sign_d  = sign_x;
               exp_d   = {2'b00, a_e} - {2'b00, b_e} + BIAS;
               div_d   = {1'b1, b_f};
               rem_d   = step_rem_out;
               quo_d   = {{(QW-1){1'b0}}, step_bit};
               cnt_d   = '0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            rem_d = step_rem_out;
            quo_d = {quo_q[QW-2:0], step_bit};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MAN_W + 1)) begin
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            quotient_d = n_res;
            flags_d    = n_flg;
            state_d    = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers; reset discards any computation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         div_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         quotient_q <= '0;
         flags_q    <= 4'b0000;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         div_q      <= div_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         quotient_q <= quotient_d;
         flags_q    <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed-vector bench for fp_div_iter at single-precision widths.
// Checks latency, results, flags, handshake, backpressure hold and mid-operation reset.
// Expected 1/3 result follows FP_DIV_ROUND_EN, like the design.
module tb_fp_div_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] quotient;
   logic [3:0]  flags;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int acc_cyc = 0;

`ifdef FP_DIV_ROUND_EN
   localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
   localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

   fp_div_iter #(
      .EXP_W(8),
      .MAN_W(23)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .dividend (dividend),
      .divisor  (divisor),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .quotient (quotient),
      .flags    (flags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   // present operands at a negedge, accept on the next posedge, then scramble the inputs
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      wait_ready();
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // lat = index of the edge (counted from accept) that first samples out_valid high
   task automatic wait_result(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
   endtask

   task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [3:0] exp_f, input int exp_lat);
      int lat;
      issue(a, b);
      wait_result(lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_q"}, quotient, exp_q);
      check({tag, "_flg"}, {28'd0, flags}, {28'd0, exp_f});
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_hand"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int first_acc;
      int lat;
      int seen;

      // reset state
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_quotient", quotient, 32'd0);
      check("rst_flags", {28'd0, flags}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // normal operands, back to back for throughput
      do_div("six_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
      first_acc = acc_cyc;
      do_div("one_third", 32'h3F800000, 32'h40400000, THIRD, 4'b0000, 28);
      check("throughput", 32'(acc_cyc - first_acc), 32'd29);
      do_div("neg_six_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28);
      do_div("exact_one", 32'h3FC00000, 32'h3FC00000, 32'h3F800000, 4'b0000, 28);

      // special operands
      do_div("div0", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2);
      do_div("neg_div0", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 2);
      do_div("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2);
      do_div("ninf_fin", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2);
      do_div("inf_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 2);
      do_div("nan_in", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0000, 2);
      do_div("fin_ninf", 32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 2);
      do_div("subnorm", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 2);

      // exponent range
      do_div("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28);
      do_div("underflow", 32'h00800000, 32'h4B000000, 32'h00000000, 4'b0001, 28);

      // backpressure: hold the result, pulse ignored operands
      out_ready = 1'b0;
      issue(32'hC0C00000, 32'h40000000);
      wait_result(lat);
      check("bp_lat", 32'(lat), 32'd28);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         dividend = 32'h3F800000;
         divisor  = 32'h00000000;
         @(negedge clk);
         check("bp_q", quotient, 32'hC0400000);
         check("bp_flg", {28'd0, flags}, 32'd0);
         check("bp_vld", 32'(out_valid), 32'd1);
         check("bp_rdy", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hand", 32'(out_valid), 32'd0);
      check("bp_idle", 32'(in_ready), 32'd1);
      @(negedge clk);
      check("bp_no_accept", 32'(in_ready), 32'd1);
      do_div("bp_after", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);

      // reset in ITER cycle 10
      issue(32'h40C00000, 32'h40000000);
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld", 32'(out_valid), 32'd0);
      check("mid_rst_rdy", 32'(in_ready), 32'd0);
      check("mid_rst_q", quotient, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid_rel_rdy", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mid_no_result", 32'(seen), 32'd0);
      check("mid_idle_rdy", 32'(in_ready), 32'd1);
      do_div("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
